apb_rr_master: RTL and testbench

- Multi-requester APB master that shares one APB bus (4-bit address, 8-bit data) between NREQ local requesters using round-robin arbitration.
- Converts each granted request into a standard APB SETUP -> ACCESS transfer with pready wait states.
- Returns read data and a one-cycle completion pulse to the winning requester.
- Sits between on-chip initiators (test sequencers, config engines) and the APB slave fabric.

---
 rtl/apb_rr_master.sv | 191 +++++++++++++++++++
 tb/tb_apb_rr_master.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_rr_master.sv
// APB master shared by NREQ local requesters with round-robin arbitration.
// Each grant becomes one SETUP -> ACCESS transfer; completion is a one-cycle req_done pulse.
module apb_rr_master #(
   parameter int NREQ = 2,
   parameter int AW   = 4,
   parameter int DW   = 8
) (
   input  logic              pclk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ-1:0]    req_write,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_wdata,
   output logic [NREQ-1:0]    req_done,
   output logic [DW-1:0]      req_rdata,
   output logic              busy,
   output logic [AW-1:0]      paddr,
   output logic              pwrite,
   output logic              psel,
   output logic              penable,
   output logic [DW-1:0]      pwdata,
   input  logic [DW-1:0]      prdata,
   input  logic              pready,
   output logic [1:0]         dbg_state
);

   localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [GW-1:0]     grant_q, grant_d;
   logic [GW-1:0]     last_q, last_d;
   logic              psel_q, psel_d;
   logic              penable_q, penable_d;
   logic              pwrite_q, pwrite_d;
   logic [AW-1:0]     paddr_q, paddr_d;
   logic [DW-1:0]     pwdata_q, pwdata_d;
   logic [NREQ-1:0]   done_q, done_d;
   logic [DW-1:0]     rdata_q, rdata_d;
   logic              busy_q, busy_d;

   logic [NREQ-1:0]   grant_oh;
   logic [NREQ-1:0]   arb_cand;
   logic [GW-1:0]     arb_last;
   logic [GW:0]       arb_result;
   logic              arb_found;
   logic [GW-1:0]     arb_idx;
   logic [AW-1:0]     sel_addr;
   logic [DW-1:0]     sel_wdata;
   logic              sel_write;

   // Search upward from last+1 with wrap; returns {found, index}.
   function automatic logic [GW:0] rr_pick(input logic [NREQ-1:0] cand,
                                           input logic [GW-1:0]   last);
      logic          found;
      logic [GW-1:0] idx;
      int            j;
      found = 1'b0;
      idx   = '0;
      for (int i = 1; i <= NREQ; i++) begin
         j = (int'(last) + i) % NREQ;
         if (!found && cand[j]) begin
            found = 1'b1;
            idx   = GW'(j);
         end
      end
      return {found, idx};
   endfunction

   // In ACCESS the arbitration is for the transfer that follows this one, so the
   // completing requester is masked and becomes the new round-robin reference.
   always_comb begin
      grant_oh           = '0;
      grant_oh[grant_q]  = 1'b1;
      if (state_q == S_ACCESS) begin
         arb_cand = req_valid & ~grant_oh;
         arb_last = grant_q;
      end else begin
         arb_cand = req_valid;
         arb_last = last_q;
      end
      arb_result = rr_pick(arb_cand, arb_last);
      arb_found  = arb_result[GW];
      arb_idx    = arb_result[GW-1:0];
      sel_addr   = req_addr[int'(arb_idx)*AW +: AW];
      sel_wdata  = req_wdata[int'(arb_idx)*DW +: DW];
      sel_write  = req_write[arb_idx];
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      last_d    = last_q;
      psel_d    = psel_q;
      penable_d = penable_q;
      pwrite_d  = pwrite_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      rdata_d   = rdata_q;
      done_d    = '0;
      case (state_q)
         S_IDLE: begin
            if (arb_found) begin
               grant_d   = arb_idx;
               paddr_d   = sel_addr;
               pwrite_d  = sel_write;
               pwdata_d  = sel_wdata;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               state_d   = S_SETUP;
            end
         end
         S_SETUP: begin
            penable_d = 1'b1;
            state_d   = S_ACCESS;
         end
         S_ACCESS: begin
            if (pready) begin
               done_d = grant_oh;
               last_d = grant_q;
               if (!pwrite_q) begin
                  rdata_d = prdata;
               end
               if (arb_found) begin
                  grant_d   = arb_idx;
                  paddr_d   = sel_addr;
                  pwrite_d  = sel_write;
                  pwdata_d  = sel_wdata;
                  psel_d    = 1'b1;
                  penable_d = 1'b0;
                  state_d   = S_SETUP;
               end else begin
                  psel_d    = 1'b0;
                  penable_d = 1'b0;
                  state_d   = S_IDLE;
               end
            end
         end
         default: begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            state_d   = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge pclk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         grant_q   <= '0;
         last_q    <= GW'(NREQ - 1);
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         done_q    <= '0;
         rdata_q   <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         last_q    <= last_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         done_q    <= done_d;
         rdata_q   <= rdata_d;
         busy_q    <= busy_d;
      end
   end

   assign psel      = psel_q;
   assign penable   = penable_q;
   assign pwrite    = pwrite_q;
   assign paddr     = paddr_q;
   assign pwdata    = pwdata_q;
   assign req_done  = done_q;
   assign req_rdata = rdata_q;
   assign busy      = busy_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Directed bench for apb_rr_master: reset, single transfers, wait states,
// round-robin contention, mask rule, mid-transfer reset and operand capture.
module tb_apb_rr_master;

   localparam int NREQ = 2;
   localparam int AW   = 4;
   localparam int DW   = 8;

   logic                pclk = 1'b0;
   logic                rst_n;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_write;
   logic [NREQ*AW-1:0]  req_addr;
   logic [NREQ*DW-1:0]  req_wdata;
   logic [NREQ-1:0]     req_done;
   logic [DW-1:0]       req_rdata;
   logic                busy;
   logic [AW-1:0]       paddr;
   logic                pwrite;
   logic                psel;
   logic                penable;
   logic [DW-1:0]       pwdata;
   logic [DW-1:0]       prdata;
   logic                pready;
   logic [1:0]          dbg_state;

   int errors = 0;
   int checks = 0;
   logic [NREQ-1:0] exp_q[$];

   always #5 pclk = ~pclk;

   apb_rr_master #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
      .pclk      (pclk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_done  (req_done),
      .req_rdata (req_rdata),
      .busy      (busy),
      .paddr     (paddr),
      .pwrite    (pwrite),
      .psel      (psel),
      .penable   (penable),
      .pwdata    (pwdata),
      .prdata    (prdata),
      .pready    (pready),
      .dbg_state (dbg_state)
   );

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      prdata = '0; pready = 1'b1;
      tick(); tick();
      checks++;
      if ({psel, penable, busy, pwrite} !== 4'b0000)
         begin errors++; $display("FAIL reset_ctrl: psel/penable/busy/pwrite got %b expected 0000", {psel, penable, busy, pwrite}); end
      checks++;
      if (paddr !== 4'h0 || pwdata !== 8'h00)
         begin errors++; $display("FAIL reset_bus: paddr=%h pwdata=%h expected 0/00", paddr, pwdata); end
      checks++;
      if (req_done !== 2'b00 || req_rdata !== 8'h00)
         begin errors++; $display("FAIL reset_resp: done=%b rdata=%h expected 00/00", req_done, req_rdata); end
      checks++;
      if (dbg_state !== 2'd0)
         begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_write();
      int psel_cnt = 0, pen_cnt = 0, done_cnt = 0, done_cyc = 0;
      logic [NREQ-1:0] done_val = '0;
      req_write = 2'b01; req_addr[3:0] = 4'd2; req_wdata[7:0] = 8'd5; pready = 1'b1;
      req_valid = 2'b01;
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (c == 1) begin
            checks++;
            if ({psel, penable, pwrite, busy} !== 4'b1011 || paddr !== 4'd2 || pwdata !== 8'd5)
               begin errors++; $display("FAIL wr_setup: psel/pen/pwr/busy=%b paddr=%h pwdata=%h expected 1011/2/05", {psel, penable, pwrite, busy}, paddr, pwdata); end
         end
         if (psel) psel_cnt++;
         if (penable) pen_cnt++;
         if (req_done !== 2'b00) begin
            done_cnt++; done_cyc = c; done_val = req_done; req_valid[0] = 1'b0;
         end
      end
      checks++;
      if (psel_cnt != 2 || pen_cnt != 1)
         begin errors++; $display("FAIL wr_strobes: psel cycles=%0d penable cycles=%0d expected 2/1", psel_cnt, pen_cnt); end
      checks++;
      if (done_cnt != 1 || done_cyc != 3 || done_val !== 2'b01)
         begin errors++; $display("FAIL wr_done: count=%0d cycle=%0d value=%b expected 1/3/01", done_cnt, done_cyc, done_val); end
      checks++;
      if (req_rdata !== 8'h00 || paddr !== 4'd2 || busy !== 1'b0)
         begin errors++; $display("FAIL wr_idle_hold: rdata=%h paddr=%h busy=%b expected 00/2/0", req_rdata, paddr, busy); end
   endtask

   task automatic test_read_wait();
      int acc = 0, done_cnt = 0, done_cyc = 0;
      req_write = 2'b00; req_addr[7:4] = 4'd3; prdata = 8'h0A; pready = 1'b0;
      req_valid = 2'b10;
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (psel && penable) begin
            acc++;
            checks++;
            if (paddr !== 4'd3 || pwrite !== 1'b0)
               begin errors++; $display("FAIL rd_stable: cycle %0d paddr=%h pwrite=%b expected 3/0", c, paddr, pwrite); end
            pready = (acc >= 3);
         end
         if (req_done !== 2'b00) begin
            done_cnt++; done_cyc = c; req_valid[1] = 1'b0;
            checks++;
            if (req_done !== 2'b10 || req_rdata !== 8'h0A)
               begin errors++; $display("FAIL rd_done: done=%b rdata=%h expected 10/0a", req_done, req_rdata); end
         end
      end
      checks++;
      if (acc != 3 || done_cnt != 1 || done_cyc != 5)
         begin errors++; $display("FAIL rd_timing: access cycles=%0d dones=%0d done cycle=%0d expected 3/1/5", acc, done_cnt, done_cyc); end
      pready = 1'b1;
   endtask

   task automatic test_contention();
      int ndone = 0, nsetup = 0, bound = 0;
      bit started = 0;
      logic [NREQ-1:0] exp_oh;
      logic [AW-1:0]   exp_addr;
      exp_q = {};
      exp_q.push_back(2'b01); exp_q.push_back(2'b10);
      exp_q.push_back(2'b01); exp_q.push_back(2'b10);
      rst_n = 1'b0; req_valid = 2'b11; req_write = 2'b11;
      req_addr = {4'd2, 4'd1}; req_wdata = {8'h22, 8'h11}; pready = 1'b1;
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 30 && ndone < 4; c++) begin
         tick();
         if (started) begin
            checks++;
            if (psel !== 1'b1) begin errors++; $display("FAIL cont_psel_gap: cycle %0d psel=%b expected 1", c, psel); end
         end
         if (psel) started = 1;
         if (psel && !penable && nsetup < 4) begin
            exp_addr = (nsetup % 2 == 0) ? 4'd1 : 4'd2;
            checks++;
            if (paddr !== exp_addr) begin errors++; $display("FAIL cont_grant: setup %0d paddr=%h expected %h", nsetup, paddr, exp_addr); end
            nsetup++;
         end
         if (req_done !== 2'b00) begin
            exp_oh = exp_q.pop_front();
            checks++;
            if (req_done !== exp_oh) begin errors++; $display("FAIL cont_done: pulse %0d got %b expected %b", ndone, req_done, exp_oh); end
            ndone++;
         end
      end
      checks++;
      if (ndone != 4) begin errors++; $display("FAIL cont_count: dones=%0d expected 4", ndone); end
      req_valid = 2'b00;
      while (busy && bound < 12) begin tick(); bound++; end
      tick();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL cont_drain: busy=%b expected 0", busy); end
   endtask

   task automatic test_mask_rule();
      int nsetup = 0, ndone = 0, first_cyc = 0, second_cyc = 0;
      bit prev_done = 0;
      req_write = 2'b01; req_addr[3:0] = 4'd4; req_wdata[7:0] = 8'h33; pready = 1'b1;
      req_valid = 2'b01;
      for (int c = 1; c <= 14; c++) begin
         tick();
         if (prev_done) req_valid[0] = 1'b0;
         prev_done = 0;
         if (psel && !penable) nsetup++;
         if (req_done !== 2'b00) begin
            ndone++; prev_done = 1;
            if (ndone == 1) begin
               first_cyc = c;
               checks++;
               if (psel !== 1'b0) begin errors++; $display("FAIL mask_gap: psel=%b in done cycle expected 0", psel); end
            end else begin
               second_cyc = c;
            end
         end
      end
      checks++;
      if (nsetup != 2 || ndone != 2)
         begin errors++; $display("FAIL mask_count: setups=%0d dones=%0d expected 2/2", nsetup, ndone); end
      checks++;
      if (second_cyc - first_cyc != 3)
         begin errors++; $display("FAIL mask_spacing: done distance=%0d expected 3", second_cyc - first_cyc); end
   endtask

   task automatic test_reset_mid();
      int bound = 0, ndone = 0;
      logic [NREQ-1:0] first_done = '0;
      req_write = 2'b00; req_addr[3:0] = 4'd5; prdata = 8'h5A; pready = 1'b0;
      req_valid = 2'b01;
      while (!(psel && penable) && bound < 10) begin tick(); bound++; end
      checks++;
      if (!(psel && penable)) begin errors++; $display("FAIL rst_reach_access: psel=%b penable=%b expected 1/1", psel, penable); end
      tick();
      rst_n = 1'b0;
      tick();
      checks++;
      if ({psel, penable, busy} !== 3'b000 || req_done !== 2'b00)
         begin errors++; $display("FAIL rst_abort: psel/pen/busy=%b done=%b expected 000/00", {psel, penable, busy}, req_done); end
      checks++;
      if (req_rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata: got %h expected 00", req_rdata); end
      req_valid = 2'b11; req_addr = {4'd7, 4'd6}; pready = 1'b1;
      tick();
      checks++;
      if (req_done !== 2'b00) begin errors++; $display("FAIL rst_no_done: got %b expected 00", req_done); end
      rst_n = 1'b1;
      tick();
      checks++;
      if (psel !== 1'b1 || paddr !== 4'd6)
         begin errors++; $display("FAIL rst_priority: psel=%b paddr=%h expected 1/6", psel, paddr); end
      bound = 0;
      while ((req_valid != 2'b00 || busy) && bound < 20) begin
         if (req_done !== 2'b00) begin
            if (ndone == 0) first_done = req_done;
            ndone++;
            req_valid = req_valid & ~req_done;
         end
         tick(); bound++;
      end
      if (req_done !== 2'b00) ndone++;
      checks++;
      if (ndone != 2 || first_done !== 2'b01)
         begin errors++; $display("FAIL rst_after: dones=%0d first=%b expected 2/01", ndone, first_done); end
      tick();
   endtask

   task automatic test_operand_change();
      int acc = 0, done_cnt = 0;
      req_write = 2'b01; req_addr[3:0] = 4'd8; req_wdata[7:0] = 8'h44; pready = 1'b0;
      req_valid = 2'b01;
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (busy) begin
            checks++;
            if (paddr !== 4'd8 || pwdata !== 8'h44 || pwrite !== 1'b1)
               begin errors++; $display("FAIL op_capture: cycle %0d paddr=%h pwdata=%h pwrite=%b expected 8/44/1", c, paddr, pwdata, pwrite); end
         end
         if (psel && !penable) begin
            req_addr[3:0] = 4'd9; req_wdata[7:0] = 8'h55;
         end
         if (psel && penable) begin
            acc++; req_valid[0] = 1'b0; pready = (acc >= 2);
         end
         if (req_done !== 2'b00) begin
            done_cnt++;
            checks++;
            if (req_done !== 2'b01) begin errors++; $display("FAIL op_done: got %b expected 01", req_done); end
         end
      end
      checks++;
      if (done_cnt != 1 || paddr !== 4'd8 || busy !== 1'b0)
         begin errors++; $display("FAIL op_end: dones=%0d paddr=%h busy=%b expected 1/8/0", done_cnt, paddr, busy); end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_read_wait();
      test_contention();
      test_mask_rule();
      test_reset_mid();
      test_operand_change();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
